pc_next_unit: RTL

- Program-counter register and next-PC selector for the MIPS fetch stage.
- Consumes the 28-bit word-aligned jump offset from the 26-to-28-bit jump shifter; also takes branch and jump-register redirects from decode.
- Drives the instruction-memory fetch handshake.
- Redirects that arrive while fetch is blocked are held in a pending register and applied on the next accepted fetch.

---
 rtl/pc_next_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the fetch stage, including the
// instruction-memory request handshake and a pending-redirect register.
// Latency: a redirect coincident with Fetch_fire reaches Pc at the next edge.
// Backpressure: ~Imem_ready or Stall blocks the fire; redirects that arrive
// while blocked are held, newest wins, and applied on the next fire.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   Stall           pipeline hazard stall, gates Fetch_fire
//   Id_pc_plus4     PC+4 of the decode-stage instruction (branch base, jump region)
//   Jump/Jump_target28            J/JAL pulse and shifted instr_index
//   Branch_taken/Branch_offset    taken-branch pulse and shifted sign-extended offset
//   Jr/Jr_target                  JR/JALR pulse and register value
//   Imem_ready      instruction memory can accept a request
//   Pc, Pc_plus4    current fetch address and Pc + 4
//   Fetch_req       request to instruction memory (low only in BOOT)
//   Fetch_fire      Fetch_req & Imem_ready & ~Stall
//   Misaligned      sticky flag, set by a JR target with nonzero bits [1:0]
//   Redirect_cnt    saturating count of redirects written to Pc
//
// Optional feature: define PC_REDIRECT_CNT_EN to build the redirect counter;
// otherwise Redirect_cnt is tied to zero.

module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic [31:0]      Id_pc_plus4,
    input  logic             Jump,
    input  logic [27:0]      Jump_target28,
    input  logic             Branch_taken,
    input  logic [31:0]      Branch_offset,
    input  logic             Jr,
    input  logic [31:0]      Jr_target,
    input  logic             Imem_ready,
    output logic [31:0]      Pc,
    output logic [31:0]      Pc_plus4,
    output logic             Fetch_req,
    output logic             Fetch_fire,
    output logic             Misaligned,
    output logic [CNT_W-1:0] Redirect_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t      state, state_nxt;
    // Only word addresses are stored, so Pc[1:0] is 00 by construction.
    logic [31:2] pc_q, pc_nxt;
    logic [31:2] pend_tgt, pend_tgt_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic        mis_q;

    logic        redir_vld;
    logic [31:2] redir_tgt;
    logic [31:2] br_tgt;

    // Byte-offset bits of word-aligned inputs carry no information.
    logic        unused_low_bits;
    assign unused_low_bits = ^{Id_pc_plus4[1:0], Branch_offset[1:0], Jump_target28[1:0]};

    // Both operands are word aligned, so the add is done on word addresses.
    assign br_tgt = Id_pc_plus4[31:2] + Branch_offset[31:2];

    // Priority Jr > Jump > Branch; only the winner's target is used.
    assign redir_vld = Jr | Jump | Branch_taken;
    always_comb begin
        redir_tgt = br_tgt;
        if (Jr)
            redir_tgt = Jr_target[31:2];
        else if (Jump)
            redir_tgt = {Id_pc_plus4[31:28], Jump_target28[27:2]};
    end

    assign Fetch_req  = (state != BOOT);
    assign Fetch_fire = Fetch_req & Imem_ready & ~Stall;
    assign Pc         = {pc_q, 2'b00};
    assign Pc_plus4   = {pc_q + 30'd1, 2'b00};
    assign Misaligned = mis_q;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_q;
        pend_tgt_nxt = pend_tgt;
        pend_vld_nxt = pend_vld;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (Fetch_fire) begin
                    pc_nxt = redir_vld ? redir_tgt : (pc_q + 30'd1);
                end else if (redir_vld) begin
                    pend_tgt_nxt = redir_tgt;
                    pend_vld_nxt = 1'b1;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                if (Fetch_fire) begin
                    // A fresh pulse supersedes the held target.
                    pc_nxt       = redir_vld ? redir_tgt : pend_tgt;
                    pend_vld_nxt = 1'b0;
                    state_nxt    = RUN;
                end else if (redir_vld) begin
                    pend_tgt_nxt = redir_tgt;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc_q     <= RESET_PC[31:2];
            pend_tgt <= '0;
            pend_vld <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            pend_tgt <= pend_tgt_nxt;
            pend_vld <= pend_vld_nxt;
            if (Jr && (Jr_target[1:0] != 2'b00))
                mis_q <= 1'b1;
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             redir_apply;

    // A redirect lands in Pc on a fire with a live pulse or out of PEND.
    assign redir_apply  = Fetch_fire & (redir_vld | (state == PEND));
    assign Redirect_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (redir_apply && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
    end
`else
    assign Redirect_cnt = '0;
`endif

endmodule
